jtag_req_ctrl: RTL and testbench

Core-clock-domain controller that turns debug requests captured by the JTAG port into uP-side actions: memory reads and writes, pause, resume and single-step. It synchronises the TCK-domain request toggle into `i_clk`, decodes the latched command byte and sequences a memory transaction. It arbitrates the shared memory bus between the core and the debugger, and returns read data and a completion toggle to the JTAG port.

---
 rtl/jtag_pkg.sv | 29 ++
 rtl/jtag_req_ctrl_sync2.sv | 24 ++
 rtl/jtag_req_ctrl.sv | 171 +++++++++++++++++
 tb/tb_jtag_req_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG debug request path: opcodes, controller
// states and default bus widths. The JTAG port uses the same opcode constants.
package jtag_pkg;

  localparam int JTAG_ADDR_W = 16;
  localparam int JTAG_DATA_W = 16;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_SETADDR = 4'h1;
  localparam logic [3:0] OP_READ    = 4'h2;
  localparam logic [3:0] OP_WRITE   = 4'h3;
  localparam logic [3:0] OP_PAUSE   = 4'h4;
  localparam logic [3:0] OP_RESUME  = 4'h5;
  localparam logic [3:0] OP_STEP    = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ARB,
    ST_BUS,
    ST_STEP,
    ST_DONE
  } jtag_ctrl_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/jtag_req_ctrl_sync2.sv
// Two-flop synchroniser for a single-bit level crossing into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/jtag_req_ctrl.sv
// Core-domain controller executing JTAG debug requests (mem read/write, pause,
// resume, step). Define JTAG_AUTOINC_EN to post-increment addrR after each bus op.
module jtag_req_ctrl
  import jtag_pkg::*;
#(
  parameter int ADDR_W = JTAG_ADDR_W,
  parameter int DATA_W = JTAG_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_jtagReq,
  input  logic [7:0]        i_jtagCmd,
  input  logic [DATA_W-1:0] i_jtagData,
  output logic              o_jtagAck,
  output logic [DATA_W-1:0] o_jtagRdData,
  output logic              o_err,
  input  logic              i_coreReq,
  input  logic              i_coreWr,
  input  logic [ADDR_W-1:0] i_coreAddr,
  input  logic [DATA_W-1:0] i_coreWrData,
  output logic              o_coreGnt,
  output logic              o_memEn,
  output logic              o_memWr,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWrData,
  input  logic              i_memRdy,
  input  logic [DATA_W-1:0] i_memRdData,
  input  logic              i_isPaused,
  output logic              o_pause,
  output logic              o_step
);

  jtag_ctrl_state_t  state_q, state_d;
  logic              req_sync;
  logic              req_last_q, req_last_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              err_q, err_d;
  logic              pause_q, pause_d;

  // Only the opcode nibble of the command byte carries meaning.
  logic unused_cmd;
  assign unused_cmd = ^i_jtagCmd[3:0];

  sync2 u_req_sync (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .d     (i_jtagReq),
    .q     (req_sync)
  );

  // req_last_q only follows the synchroniser when a request is accepted in
  // IDLE, so a toggle arriving while busy stays pending until then.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    req_last_d = req_last_q;
    op_d       = op_q;
    data_d     = data_q;
    addr_d     = addr_q;
    ack_d      = ack_q;
    rd_d       = rd_q;
    err_d      = err_q;
    pause_d    = pause_q;

    case (state_q)
      ST_IDLE: begin
        if (req_sync != req_last_q) begin
          req_last_d = req_sync;
          op_d       = i_jtagCmd[7:4];
          data_d     = i_jtagData;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_DONE;
        if (is_mem_op(op_q)) begin
          if (i_isPaused) state_d = ST_ARB;
          else            err_d   = 1'b1;
        end else begin
          case (op_q)
            OP_NOP:     ;
            OP_SETADDR: addr_d  = ADDR_W'(data_q);
            OP_PAUSE:   pause_d = 1'b1;
            OP_RESUME: begin
              pause_d = 1'b0;
              err_d   = 1'b0;
            end
            OP_STEP: begin
              if (i_isPaused) state_d = ST_STEP;
              else            err_d   = 1'b1;
            end
            default:    err_d = 1'b1;
          endcase
        end
      end
      ST_ARB: begin
        if (!i_coreReq) state_d = ST_BUS;
      end
      ST_BUS: begin
        if (i_memRdy) begin
          if (op_q == OP_READ) rd_d = i_memRdData;
`ifdef JTAG_AUTOINC_EN
          addr_d = addr_q + ADDR_W'(1);
`else
          addr_d = addr_q;
`endif
          state_d = ST_DONE;
        end
      end
      ST_STEP: state_d = ST_DONE;
      ST_DONE: begin
        ack_d   = req_last_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      req_last_q <= 1'b0;
      op_q       <= OP_NOP;
      data_q     <= '0;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      pause_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q    <= state_d;
      req_last_q <= req_last_d;
      op_q       <= op_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      pause_q    <= pause_d;
    end
  end

  assign o_coreGnt    = (state_q != ST_BUS);
  assign o_step       = (state_q == ST_STEP);
  assign o_jtagAck    = ack_q;
  assign o_jtagRdData = rd_q;
  assign o_err        = err_q;
  assign o_pause      = pause_q;

  // The core owns the bus in every state but BUS, so its request passes
  // straight through without any added latency.
  always_comb begin
    if (o_coreGnt) begin
      o_memEn     = i_coreReq;
      o_memWr     = i_coreWr;
      o_memAddr   = i_coreAddr;
      o_memWrData = i_coreWrData;
    end else begin
      o_memEn     = 1'b1;
      o_memWr     = (op_q == OP_WRITE);
      o_memAddr   = addr_q;
      o_memWrData = data_q;
    end
  end

endmodule

// File: tb/tb_jtag_req_ctrl.sv
// Self-checking bench for jtag_req_ctrl: directed requests against a
// transaction-level model of the controller and a simple bus responder.
module tb_jtag_req_ctrl;
  import jtag_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_jtagReq;
  logic [7:0]  i_jtagCmd;
  logic [15:0] i_jtagData;
  logic        o_jtagAck;
  logic [15:0] o_jtagRdData;
  logic        o_err;
  logic        i_coreReq, i_coreWr;
  logic [15:0] i_coreAddr, i_coreWrData;
  logic        o_coreGnt, o_memEn, o_memWr;
  logic [15:0] o_memAddr, o_memWrData;
  logic        i_memRdy;
  logic [15:0] i_memRdData;
  logic        i_isPaused;
  logic        o_pause, o_step;

  always #5 clk = ~clk;

  jtag_req_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_clk(clk), .i_rstn(rst_n),
    .i_jtagReq(i_jtagReq), .i_jtagCmd(i_jtagCmd), .i_jtagData(i_jtagData),
    .o_jtagAck(o_jtagAck), .o_jtagRdData(o_jtagRdData), .o_err(o_err),
    .i_coreReq(i_coreReq), .i_coreWr(i_coreWr), .i_coreAddr(i_coreAddr),
    .i_coreWrData(i_coreWrData), .o_coreGnt(o_coreGnt),
    .o_memEn(o_memEn), .o_memWr(o_memWr), .o_memAddr(o_memAddr),
    .o_memWrData(o_memWrData), .i_memRdy(i_memRdy), .i_memRdData(i_memRdData),
    .i_isPaused(i_isPaused), .o_pause(o_pause), .o_step(o_step)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus memory seen by the responder; wait cycles before i_memRdy.
  logic [15:0] mem [logic [15:0]];
  int          mem_wait = 0;
  int          bus_cnt  = 0;
  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (rst_n && !o_coreGnt) begin
      if (bus_cnt == mem_wait) begin
        i_memRdy    = 1'b1;
        i_memRdData = mem_rd(o_memAddr);
        if (o_memWr) mem[o_memAddr] = o_memWrData;
        obs_q.push_back({o_memWr, o_memAddr, o_memWrData});
      end else begin
        i_memRdy = 1'b0;
      end
      bus_cnt++;
    end else begin
      i_memRdy = 1'b0;
      bus_cnt  = 0;
    end
  end

  int step_seen = 0;
  always @(negedge clk) if (o_step) step_seen++;

  // Transaction-level model of the controller's visible state.
  logic        m_ack   = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_pause = 1'b0;
  logic [15:0] m_rd    = 16'h0;
  logic [15:0] m_addr  = 16'h0;
  int          m_steps = 0;

  task automatic model_req(input logic [7:0] cmd, input logic [15:0] data,
                           input logic paused, input int arb_extra, output int lat);
    logic [3:0] op;
    op    = cmd[7:4];
    m_ack = ~m_ack;
    lat   = 5;
    case (op)
      OP_NOP: ;
      OP_SETADDR: m_addr = data;
      OP_READ, OP_WRITE: begin
        if (!paused) m_err = 1'b1;
        else begin
          exp_q.push_back({op == OP_WRITE, m_addr, data});
          if (op == OP_READ) m_rd = mem_rd(m_addr);
          lat = 7 + mem_wait + arb_extra;
`ifdef JTAG_AUTOINC_EN
          m_addr = m_addr + 16'h1;
`endif
        end
      end
      OP_PAUSE:  m_pause = 1'b1;
      OP_RESUME: begin m_pause = 1'b0; m_err = 1'b0; end
      OP_STEP: begin
        if (paused) begin m_steps++; lat = 6; end
        else m_err = 1'b1;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  // Between requests every visible output must match the model.
  logic quiet = 1'b0;
  always @(negedge clk) begin
    if (quiet) begin
      check("idle_ack",   o_jtagAck,    m_ack);
      check("idle_err",   o_err,        m_err);
      check("idle_pause", o_pause,      m_pause);
      check("idle_rd",    o_jtagRdData, m_rd);
      check("idle_step",  o_step,       1'b0);
      check("idle_gnt",   o_coreGnt,    1'b1);
      check("idle_memen", o_memEn,      i_coreReq);
    end
  end

  // Issue one request (called just after a negedge) and wait for its ack.
  task automatic do_req(input logic [7:0] cmd, input logic [15:0] data,
                        input int arb_extra, input string name);
    int   exp_lat;
    int   n;
    logic old;
    logic [32:0] e, o;
    quiet = 1'b0;
    model_req(cmd, data, i_isPaused, arb_extra, exp_lat);
    old        = o_jtagAck;
    i_jtagCmd  = cmd;
    i_jtagData = data;
    i_jtagReq  = ~i_jtagReq;
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (o_jtagAck == old && n < 60);
    check({name, "_lat"}, n, exp_lat);
    @(negedge clk);
    check({name, "_nbus"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, "_bus"}, o, e);
    end
    exp_q.delete();
    obs_q.delete();
    check({name, "_steps"}, step_seen, m_steps);
    quiet = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i_jtagReq = 1'b0; i_jtagCmd = 8'h0; i_jtagData = 16'h0;
    i_coreReq = 1'b0; i_coreWr = 1'b0; i_coreAddr = 16'h0; i_coreWrData = 16'h0;
    i_memRdy = 1'b0; i_memRdData = 16'h0; i_isPaused = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack",   o_jtagAck,    1'b0);
    check("rst_gnt",   o_coreGnt,    1'b1);
    check("rst_err",   o_err,        1'b0);
    check("rst_pause", o_pause,      1'b0);
    check("rst_step",  o_step,       1'b0);
    check("rst_rd",    o_jtagRdData, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (2) @(negedge clk);

    // SETADDR then READ while paused
    mem[16'h1234] = 16'hBEEF;
    do_req(8'h10, 16'h1234, 0, "setaddr");
    do_req(8'h20, 16'h0000, 0, "read");
    check("read_lit_rd",  o_jtagRdData, 16'hBEEF);
    check("read_lit_ack", o_jtagAck,    1'b0);

    // Write pair from 0xFFFF, wrapping under auto-increment
    do_req(8'h10, 16'hFFFF, 0, "setaddr_ffff");
    do_req(8'h30, 16'hA5A5, 0, "write1");
    check("write1_lit", mem_rd(16'hFFFF), 16'hA5A5);
    mem[16'hFFFF] = 16'h0000;
    do_req(8'h30, 16'hA5A5, 0, "write2");
`ifdef JTAG_AUTOINC_EN
    check("write2_lit", mem_rd(16'h0000), 16'hA5A5);
`else
    check("write2_lit", mem_rd(16'hFFFF), 16'hA5A5);
`endif

    // Memory op while the core runs is an error; RESUME clears it
    i_isPaused = 1'b0;
    do_req(8'h2F, 16'h0000, 0, "read_unpaused");
    check("unpaused_lit_err", o_err, 1'b1);
    do_req(8'h50, 16'h0000, 0, "resume");
    check("resume_lit_err", o_err, 1'b0);

    // Core holds the bus for 5 cycles of ARB during a WRITE
    i_isPaused = 1'b1;
    do_req(8'h10, 16'h0100, 0, "setaddr_100");
    i_coreReq = 1'b1; i_coreWr = 1'b1; i_coreAddr = 16'h7777; i_coreWrData = 16'h1111;
    fork
      do_req(8'h30, 16'h5A5A, 4, "write_cont");
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check("cont_gnt",  o_coreGnt, 1'b1);
          check("cont_addr", o_memAddr, 16'h7777);
        end
        i_coreReq = 1'b0;
        @(negedge clk);
        check("cont_issue", {o_coreGnt, o_memEn, o_memWr, o_memAddr}, {3'b011, 16'h0100});
      end
    join

    // READ with two BUS wait cycles
    mem_wait = 2;
    do_req(8'h10, 16'h0100, 0, "setaddr_100b");
    do_req(8'h20, 16'h0000, 0, "read_wait");
    check("read_wait_lit", o_jtagRdData, 16'h5A5A);
    mem_wait = 0;

    // Pause, step, step-while-running, bad opcode
    do_req(8'h40, 16'h0000, 0, "pause");
    check("pause_lit", o_pause, 1'b1);
    do_req(8'h60, 16'h0000, 0, "step");
    check("step_lit", step_seen, 1);
    i_isPaused = 1'b0;
    do_req(8'h61, 16'h0000, 0, "step_unpaused");
    do_req(8'h50, 16'h0000, 0, "resume2");
    i_isPaused = 1'b1;
    do_req(8'h40, 16'h0000, 0, "pause2");
    do_req(8'hF0, 16'h0000, 0, "badop");
    check("badop_lit_err",   o_err,   1'b1);
    check("badop_lit_pause", o_pause, 1'b1);

    // Reset while stalled in BUS
    quiet = 1'b0;
    mem_wait = 1000;
    i_jtagCmd = 8'h20;
    i_jtagReq = ~i_jtagReq;
    n = 0;
    while (o_coreGnt && n < 20) begin @(negedge clk); n++; end
    check("rst_reach_bus", o_coreGnt, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_gnt",   o_coreGnt,    1'b1);
    check("mrst_ack",   o_jtagAck,    1'b0);
    check("mrst_rd",    o_jtagRdData, 16'h0);
    check("mrst_err",   o_err,        1'b0);
    check("mrst_pause", o_pause,      1'b0);
    check("mrst_step",  o_step,       1'b0);
    check("mrst_memen0", o_memEn,     1'b0);
    i_coreReq = 1'b1;
    #1 check("mrst_memen1", o_memEn,  1'b1);
    i_coreReq = 1'b0;
    i_jtagReq = 1'b0;
    m_ack = 1'b0; m_err = 1'b0; m_pause = 1'b0; m_rd = 16'h0; m_addr = 16'h0;
    mem_wait = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (2) @(negedge clk);
    obs_q.delete();
    mem[16'h0000] = 16'h0042;
    do_req(8'h20, 16'h0000, 0, "read_after_rst");
    check("after_rst_lit", o_jtagRdData, 16'h0042);

    quiet = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
